// File: rtl/sram_burst_reader.sv
// Burst reader for a synchronous SRAM macro: issues credit-limited reads for a
// start address / byte count and streams returned bytes out through a small FIFO.
module sram_burst_reader #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_issue_q, rem_issue_d;
    logic [ADDR_W-1:0]   rem_accept_q, rem_accept_d;
    logic [CntW-1:0]     inflight_q, inflight_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [RD_LAT-1:0]   pipe_q, pipe_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];

    logic issue;
    logic push;
    logic pop;

    // Credit is reserved at issue so every returning byte has a FIFO slot.
    assign issue = (state_q == StRead) && (rem_issue_q != '0) &&
                   ((count_q + inflight_q) < CntW'(FIFO_DEPTH));
    assign push  = pipe_q[RD_LAT-1];
    assign pop   = (count_q != '0) && out_ready;

    assign sram_en   = issue;
    assign sram_wen  = 1'b0;
    assign sram_addr = addr_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
    assign busy      = (state_q == StRead);
    assign done      = done_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_issue_d  = rem_issue_q;
        rem_accept_d = rem_accept_q;
        done_d       = 1'b0;
        pipe_d       = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d       = start_addr;
                    rem_issue_d  = length;
                    rem_accept_d = length;
                    if (length != '0) begin
                        state_d = StRead;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    rem_issue_d = rem_issue_q - ADDR_W'(1);
                end
                if (pop) begin
                    rem_accept_d = rem_accept_q - ADDR_W'(1);
                    if (rem_accept_q == ADDR_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        pipe_d[0] = issue;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        inflight_d = inflight_q + CntW'(issue) - CntW'(push);
        count_d    = count_q + CntW'(push) - CntW'(pop);
        wr_ptr_d   = wr_ptr_q + PtrW'(push);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            rem_issue_q  <= '0;
            rem_accept_q <= '0;
            inflight_q   <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pipe_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_issue_q  <= rem_issue_d;
            rem_accept_q <= rem_accept_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pipe_q       <= pipe_d;
            done_q       <= done_d;
        end
    end

    // Storage needs no reset: pointers and count define what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a 1-cycle-latency SRAM model
// preloaded with mem[i] = i ^ 0x5A.
module tb_sram_burst_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] start_addr;
    logic [9:0] length;
    logic       sram_en;
    logic       sram_wen;
    logic [9:0] sram_addr;
    logic [7:0] sram_rdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [1024];

    sram_burst_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (sram_en) sram_rdata <= mem[sram_addr];
    end

    function automatic logic [7:0] xb(input logic [9:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs a burst with out_ready=1 from the current cycle; checks issue addresses,
    // data order and the done/busy state of the cycle after the last transfer.
    task automatic drain(input logic [9:0] a, input int n, input int iss0, input int got0,
                         input string tag);
        int iss = iss0;
        int got = got0;
        int cyc = 0;
        logic [9:0] ea;
        out_ready = 1'b1;
        while (got < n && cyc < 60) begin
            if (sram_en) begin
                ea = a + 10'(iss);
                chk({tag, " addr"}, 32'(sram_addr), 32'(ea));
                iss++;
            end
            if (out_valid) begin
                ea = a + 10'(got);
                chk({tag, " data"}, 32'(out_data), 32'(xb(ea)));
                got++;
            end
            tick();
            cyc++;
        end
        chk({tag, " bytes"}, 32'(got), 32'(n));
        chk({tag, " reads"}, 32'(iss), 32'(n));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic burst(input logic [9:0] a, input int n, input string tag);
        start = 1'b1;
        start_addr = a;
        length = 10'(n);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy_start"}, 32'(busy), 32'd1);
        drain(a, n, 0, 0, tag);
    endtask

    initial begin
        int en_cnt;
        int got;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        sram_rdata = '0;
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        length = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst en", 32'(sram_en), 0);
        chk("rst wen", 32'(sram_wen), 0);
        chk("rst addr", 32'(sram_addr), 0);
        chk("rst data", 32'(out_data), 0);
        chk("rst valid", 32'(out_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        rst_n = 1'b1;
        tick();

        // 1: exact cycle timing, 4 bytes from 0x010
        start = 1'b1; start_addr = 10'h010; length = 10'd4; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t1 busy", 32'(busy), 1);
        chk("t1 en0", 32'(sram_en), 1);
        chk("t1 addr0", 32'(sram_addr), 32'h010);
        chk("t1 nv0", 32'(out_valid), 0);
        tick();
        chk("t1 en1", 32'(sram_en), 1);
        chk("t1 addr1", 32'(sram_addr), 32'h011);
        chk("t1 nv1", 32'(out_valid), 0);
        tick();
        chk("t1 v0", 32'(out_valid), 1);
        chk("t1 d0", 32'(out_data), 32'h4A);
        chk("t1 addr2", 32'(sram_addr), 32'h012);
        tick();
        chk("t1 d1", 32'(out_data), 32'h4B);
        chk("t1 en3", 32'(sram_en), 1);
        chk("t1 addr3", 32'(sram_addr), 32'h013);
        tick();
        chk("t1 d2", 32'(out_data), 32'h48);
        chk("t1 en_off", 32'(sram_en), 0);
        tick();
        chk("t1 d3", 32'(out_data), 32'h49);
        chk("t1 nodone", 32'(done), 0);
        tick();
        chk("t1 done", 32'(done), 1);
        chk("t1 idle", 32'(busy), 0);
        chk("t1 empty", 32'(out_valid), 0);
        tick();
        chk("t1 done_pulse", 32'(done), 0);

        // 2: address wrap
        burst(10'h3FE, 4, "t2");
        tick();

        // 3: back-pressure; only FIFO_DEPTH reads go out, head stays stable
        start = 1'b1; start_addr = 10'h020; length = 10'd8; out_ready = 1'b0;
        tick();
        start = 1'b0;
        en_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (sram_en) en_cnt++;
            if (out_valid) chk("t3 stable", 32'(out_data), 32'(xb(10'h020)));
            tick();
        end
        chk("t3 reads_stalled", 32'(en_cnt), 4);
        chk("t3 en_stall", 32'(sram_en), 0);
        chk("t3 valid", 32'(out_valid), 1);
        drain(10'h020, 8, 4, 0, "t3");
        tick();

        // 4: empty burst
        start = 1'b1; start_addr = 10'h055; length = 10'd0;
        tick();
        start = 1'b0;
        chk("t4 done", 32'(done), 1);
        chk("t4 busy", 32'(busy), 0);
        chk("t4 en", 32'(sram_en), 0);
        tick();
        chk("t4 done_pulse", 32'(done), 0);
        chk("t4 busy2", 32'(busy), 0);
        chk("t4 en2", 32'(sram_en), 0);

        // 5: reset mid-burst after 2 of 6 bytes
        start = 1'b1; start_addr = 10'h200; length = 10'd6; out_ready = 1'b1;
        tick();
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && got < 2; k++) begin
            if (out_valid) got++;
            tick();
        end
        chk("t5 got2", 32'(got), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5 en", 32'(sram_en), 0);
        chk("t5 addr", 32'(sram_addr), 0);
        chk("t5 data", 32'(out_data), 0);
        chk("t5 valid", 32'(out_valid), 0);
        chk("t5 busy", 32'(busy), 0);
        chk("t5 done", 32'(done), 0);
        tick();
        chk("t5 discard", 32'(out_valid), 0);
        chk("t5 nodone", 32'(done), 0);
        burst(10'h100, 2, "t5b");
        tick();

        // 6: start while busy ignored, start in done cycle accepted
        start = 1'b1; start_addr = 10'h040; length = 10'd3;
        tick();
        start_addr = 10'h0AA; length = 10'd5;
        chk("t6 en", 32'(sram_en), 1);
        chk("t6 addr", 32'(sram_addr), 32'h040);
        tick();
        start = 1'b0;
        drain(10'h040, 3, 1, 0, "t6a");
        burst(10'h060, 2, "t6b");
        tick();
        chk("t6 idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
